occupancy_counter: RTL and testbench

Parametrised people/occupancy counter for the ultrasonic SmartCount path, fed by multiple doors, each with an active-low entry sensor and an active-low exit sensor. Raw sensor lines are synchronised, sampled on an internal tick, debounced and edge-detected. The block then keeps a saturating up/down occupancy count with full and empty flags. It is fully synchronous to clk; no derived clocks.

---
 rtl/occ_pkg.sv | 14 +
 rtl/occ_debounce.sv | 58 +++++
 rtl/occupancy_counter.sv | 162 ++++++++++++++++
 tb/tb_occupancy_counter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/occ_pkg.sv
// Shared types, constants and width helper for the occupancy counter.
package occ_pkg;

  localparam int unsigned DEFAULT_TICK_DIV = 30000;

  // Index over doors; wide enough for any realistic door count.
  typedef int unsigned door_idx_t;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/occ_debounce.sv
// One sensor line: two-flop synchroniser, tick-sampled debouncer and a
// one-clk pulse on each debounced high-to-low (activation) transition.
module occ_debounce
  import occ_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  input  logic tick,
  output logic fall
);

  localparam int unsigned SW = cnt_width(DEBOUNCE_TICKS);
  localparam logic [SW-1:0] StabLast = SW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic [SW-1:0] stab_q, stab_d;

  // Synchronise, then on each tick count how long the line has disagreed
  // with the debounced level; flip once it has disagreed long enough.
  always_comb begin
    sync_d  = {sync_q[0], raw_n};
    level_d = level_q;
    stab_d  = stab_q;
    fall    = 1'b0;
    if (tick) begin
      if (sync_q[1] != level_q) begin
        if (stab_q == StabLast) begin
          level_d = ~level_q;
          stab_d  = '0;
          // Only activation (1 -> 0) is an event; release is silent.
          fall    = level_q;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end else begin
        stab_d = '0;
      end
    end
  end

  // State registers; everything idles at the inactive (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      stab_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      stab_q  <= stab_d;
    end
  end

endmodule

// File: rtl/occupancy_counter.sv
// Multi-door occupancy counter: tick divider, per-line debouncers, event
// summation and a saturating up/down count with registered full/empty flags.
// Optional sticky overflow/underflow outputs when OCC_STICKY_ERR_EN is defined.
module occupancy_counter
  import occ_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MAX_COUNT      = 255,
  parameter int unsigned NUM_DOORS      = 2,
  parameter int unsigned TICK_DIV       = DEFAULT_TICK_DIV,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_DOORS-1:0] entry_n,
  input  logic [NUM_DOORS-1:0] exit_n,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     capacity,
  output logic [WIDTH-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 evt_in,
  output logic                 evt_out
`ifdef OCC_STICKY_ERR_EN
  ,
  output logic                 ovf_err,
  output logic                 unf_err
`endif
);

  localparam int unsigned DW = cnt_width(TICK_DIV);
  localparam int unsigned NW = cnt_width(NUM_DOORS + 1);
  // Signed intermediate wide enough for count + NUM_DOORS and for -NUM_DOORS.
  localparam int unsigned SW = WIDTH + NW + 1;
  localparam logic [DW-1:0]        DivLast  = DW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0]     MaxCount = WIDTH'(MAX_COUNT);
  localparam logic signed [SW-1:0] MaxSum   = SW'(MAX_COUNT);

  logic [DW-1:0]        div_q, div_d;
  logic                 tick;
  logic [NUM_DOORS-1:0] entry_ev, exit_ev;
  logic [NW-1:0]        n_in, n_out;
  logic signed [SW-1:0] sum;
  logic                 over, under;
  logic [WIDTH-1:0]     clamped;

  logic [WIDTH-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 evt_in_q, evt_in_d;
  logic                 evt_out_q, evt_out_d;

  // Sample tick divider: one-clk tick at the last divider value.
  always_comb begin
    tick  = (div_q == DivLast);
    div_d = tick ? '0 : div_q + DW'(1);
  end

  for (genvar g = 0; g < NUM_DOORS; g++) begin : g_door
    occ_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_entry (
      .clk  (clk),
      .rst  (rst),
      .raw_n(entry_n[g]),
      .tick (tick),
      .fall (entry_ev[g])
    );

    occ_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_exit (
      .clk  (clk),
      .rst  (rst),
      .raw_n(exit_n[g]),
      .tick (tick),
      .fall (exit_ev[g])
    );
  end

  // Count events, net entries against exits, then clamp to 0..MAX_COUNT.
  always_comb begin
    n_in  = '0;
    n_out = '0;
    for (door_idx_t i = 0; i < NUM_DOORS; i++) begin
      n_in  = n_in + NW'(entry_ev[i]);
      n_out = n_out + NW'(exit_ev[i]);
    end
    sum = $signed({{(NW + 1){1'b0}}, count_q})
        + $signed({{(WIDTH + 1){1'b0}}, n_in})
        - $signed({{(WIDTH + 1){1'b0}}, n_out});
    under = sum[SW-1];
    over  = !under && (sum > MaxSum);
    if (under) begin
      clamped = '0;
    end else if (over) begin
      clamped = MaxCount;
    end else begin
      clamped = sum[WIDTH-1:0];
    end
  end

  // Next count, event pulses and flags; clr wins over a coincident update.
  always_comb begin
    count_d   = clr ? '0 : clamped;
    evt_in_d  = (n_in != '0);
    evt_out_d = (n_out != '0);
    full_d    = (count_q >= capacity);
    empty_d   = (count_q == '0);
  end

  // Main state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      evt_in_q  <= 1'b0;
      evt_out_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      evt_in_q  <= evt_in_d;
      evt_out_q <= evt_out_d;
    end
  end

  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign evt_in  = evt_in_q;
  assign evt_out = evt_out_q;

`ifdef OCC_STICKY_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky clamp indicators; cleared together with the count.
  always_comb begin
    ovf_d = clr ? 1'b0 : (ovf_q | over);
    unf_d = clr ? 1'b0 : (unf_q | under);
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`endif

endmodule

// File: tb/tb_occupancy_counter.sv
// Self-checking bench for occupancy_counter with a fast tick (TICK_DIV=4).
// A cycle-level model from the behavioural rules is compared on every clk;
// directed scenarios add literal expectations. Honours OCC_STICKY_ERR_EN.
module tb_occupancy_counter;

  localparam int ND  = 2;
  localparam int TD  = 4;
  localparam int DB  = 3;
  localparam int MAX = 255;
  localparam int CAP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] entry_n;
  logic [ND-1:0] exit_n;
  logic          clr;
  logic [7:0]    capacity;
  logic [7:0]    count;
  logic          full, empty, evt_in, evt_out;
`ifdef OCC_STICKY_ERR_EN
  logic          ovf_err, unf_err;
`endif

  occupancy_counter #(
    .WIDTH         (8),
    .MAX_COUNT     (MAX),
    .NUM_DOORS     (ND),
    .TICK_DIV      (TD),
    .DEBOUNCE_TICKS(DB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .entry_n (entry_n),
    .exit_n  (exit_n),
    .clr     (clr),
    .capacity(capacity),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .evt_in  (evt_in),
    .evt_out (evt_out)
`ifdef OCC_STICKY_ERR_EN
    ,
    .ovf_err (ovf_err),
    .unf_err (unf_err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ein_cnt = 0;
  int eout_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: lines 0..ND-1 are entries, ND..2ND-1 are exits.
  int m_div;
  bit m_s1[2*ND];
  bit m_s2[2*ND];
  bit m_lvl[2*ND];
  int m_stab[2*ND];
  int m_count;
  bit m_full, m_empty, m_ein, m_eout;
  int m_nin, m_nout, m_sum;
  bit m_tick;
  bit m_raw[2*ND];
`ifdef OCC_STICKY_ERR_EN
  bit m_ovf, m_unf;
`endif

  always @(posedge clk) begin
    for (int l = 0; l < ND; l++) begin
      m_raw[l]      = entry_n[l];
      m_raw[ND + l] = exit_n[l];
    end
    if (rst) begin
      m_div = 0;
      for (int l = 0; l < 2 * ND; l++) begin
        m_s1[l] = 1'b1; m_s2[l] = 1'b1; m_lvl[l] = 1'b1; m_stab[l] = 0;
      end
      m_count = 0; m_full = 1'b0; m_empty = 1'b1; m_ein = 1'b0; m_eout = 1'b0;
`ifdef OCC_STICKY_ERR_EN
      m_ovf = 1'b0; m_unf = 1'b0;
`endif
    end else begin
      m_tick = (m_div == TD - 1);
      m_nin = 0;
      m_nout = 0;
      m_full = (m_count >= CAP);
      m_empty = (m_count == 0);
      if (m_tick) begin
        for (int l = 0; l < 2 * ND; l++) begin
          if (m_s2[l] != m_lvl[l]) begin
            m_stab[l]++;
            if (m_stab[l] == DB) begin
              m_lvl[l] = !m_lvl[l];
              m_stab[l] = 0;
              if (!m_lvl[l]) begin
                if (l < ND) m_nin++;
                else m_nout++;
              end
            end
          end else begin
            m_stab[l] = 0;
          end
        end
      end
      m_ein = (m_nin > 0);
      m_eout = (m_nout > 0);
      m_sum = m_count + m_nin - m_nout;
      if (clr) begin
        m_count = 0;
`ifdef OCC_STICKY_ERR_EN
        m_ovf = 1'b0; m_unf = 1'b0;
`endif
      end else begin
`ifdef OCC_STICKY_ERR_EN
        if (m_sum > MAX) m_ovf = 1'b1;
        if (m_sum < 0) m_unf = 1'b1;
`endif
        m_count = (m_sum < 0) ? 0 : (m_sum > MAX) ? MAX : m_sum;
      end
      m_div = (m_div + 1) % TD;
      for (int l = 0; l < 2 * ND; l++) begin
        m_s2[l] = m_s1[l];
        m_s1[l] = m_raw[l];
      end
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", int'(count), m_count);
      check("full", int'(full), int'(m_full));
      check("empty", int'(empty), int'(m_empty));
      check("evt_in", int'(evt_in), int'(m_ein));
      check("evt_out", int'(evt_out), int'(m_eout));
`ifdef OCC_STICKY_ERR_EN
      check("ovf_err", int'(ovf_err), int'(m_ovf));
      check("unf_err", int'(unf_err), int'(m_unf));
`endif
      if (evt_in) ein_cnt++;
      if (evt_out) eout_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the selected lines active long enough to debounce, then release.
  task automatic pulse(input logic [ND-1:0] en_mask, input logic [ND-1:0] ex_mask);
    @(negedge clk);
    entry_n = ~en_mask;
    exit_n  = ~ex_mask;
    wait_clk(20);
    entry_n = '1;
    exit_n  = '1;
    wait_clk(24);
  endtask

  // Compare DUT count and model count against a hand-computed value.
  task automatic pin_count(input string name, input int exp);
    #1;
    check({name, "_dut"}, int'(count), exp);
    check({name, "_model"}, m_count, exp);
  endtask

  int e0, x0;

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    entry_n = '1;
    exit_n = '1;
    capacity = 8'(CAP);
    wait_clk(3);
    chk_en = 1'b1;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_full", int'(full), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_evt_in", int'(evt_in), 0);
    @(negedge clk);
    rst = 1'b0;

    // Single entry.
    e0 = ein_cnt;
    pulse(2'b01, 2'b00);
    pin_count("single", 1);
    check("single_evts", ein_cnt - e0, 1);
    check("single_empty", int'(empty), 0);

    // Glitch rejection on exit door 1: at most two low tick samples each.
    x0 = eout_cnt;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exit_n[1] = 1'b0;
      wait_clk(7);
      exit_n[1] = 1'b1;
      wait_clk(9);
    end
    pin_count("glitch", 1);
    check("glitch_evts", eout_cnt - x0, 0);

    // Full flag at capacity, cleared again by one exit.
    pulse(2'b01, 2'b00);
    pulse(2'b10, 2'b00);
    pin_count("full3", 3);
    check("full3_flag", int'(full), 1);
    pulse(2'b00, 2'b01);
    pin_count("exit2", 2);
    check("exit2_flag", int'(full), 0);

    // Saturation: 126 double entries -> 254, one more -> 255.
    for (int k = 0; k < 126; k++) pulse(2'b11, 2'b00);
    pulse(2'b01, 2'b00);
    pin_count("preload", 255);
    e0 = ein_cnt;
    pulse(2'b11, 2'b00);
    pin_count("sat", 255);
    check("sat_evt", ein_cnt - e0, 1);
`ifdef OCC_STICKY_ERR_EN
    check("sat_ovf", int'(ovf_err), 1);
`endif
    // Simultaneous in and out at the ceiling net out with no loss.
    pulse(2'b01, 2'b10);
    pin_count("sat_net", 255);

    // Plain clear.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wait_clk(2);
    pin_count("clr", 0);
    check("clr_empty", int'(empty), 1);
`ifdef OCC_STICKY_ERR_EN
    check("clr_ovf", int'(ovf_err), 0);
`endif

    // Underflow: simultaneous in/out at zero nets to zero, then exit alone.
    pulse(2'b10, 2'b01);
    pin_count("net0", 0);
`ifdef OCC_STICKY_ERR_EN
    check("net0_unf", int'(unf_err), 0);
`endif
    x0 = eout_cnt;
    pulse(2'b00, 2'b01);
    pin_count("unf", 0);
    check("unf_evt", eout_cnt - x0, 1);
`ifdef OCC_STICKY_ERR_EN
    check("unf_err", int'(unf_err), 1);
`endif

    // Build to 5, then clear across an entry event.
    pulse(2'b11, 2'b00);
    pulse(2'b11, 2'b00);
    pulse(2'b01, 2'b00);
    pin_count("five", 5);
    e0 = ein_cnt;
    @(negedge clk);
    clr = 1'b1;
    pulse(2'b01, 2'b00);
    clr = 1'b0;
    wait_clk(2);
    pin_count("clr_evt", 0);
    check("clr_evt_pulse", ein_cnt - e0, 1);

    // Reset during a partial debounce, line released while in reset.
    pulse(2'b01, 2'b00);
    pin_count("pre_rst", 1);
    @(negedge clk);
    entry_n[0] = 1'b0;
    wait_clk(10);
    rst = 1'b1;
    entry_n[0] = 1'b1;
    wait_clk(3);
    #1;
    check("rst2_count", int'(count), 0);
    check("rst2_full", int'(full), 0);
    check("rst2_empty", int'(empty), 1);
    check("rst2_evt_in", int'(evt_in), 0);
    check("rst2_evt_out", int'(evt_out), 0);
`ifdef OCC_STICKY_ERR_EN
    check("rst2_ovf", int'(ovf_err), 0);
    check("rst2_unf", int'(unf_err), 0);
`endif
    e0 = ein_cnt;
    @(negedge clk);
    rst = 1'b0;
    wait_clk(40);
    pin_count("post_rst", 0);
    check("post_rst_evts", ein_cnt - e0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
